load_store_unit: RTL and testbench

- Sits between the core's execute stage and data_mem. Translates RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) at byte addresses into word accesses on data_mem.
- Extracts and extends load data.
- Performs read-modify-write for sub-word stores, because data_mem only writes whole words.
- Multi-cycle. Uses a valid/ready request handshake and a one-cycle response pulse.

---
 rtl/load_store_unit.sv | 203 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I byte/half/word loads and stores onto a word-only data_mem,
//            with sub-word stores done as read-modify-write.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32   // lane logic assumes 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_STORE  = 3'd2;
    localparam logic [2:0] c_RMW_RD = 3'd3;
    localparam logic [2:0] c_RMW_WR = 3'd4;
    localparam logic [2:0] c_RESP   = 3'd5;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [2:0]              r_state;
    logic [2:0]              w_next_state;
    logic [2:0]              r_funct3;
    logic [ADDR_WIDTH+1:0]   r_addr;
    logic [15:0]             r_wdata;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic                    w_f3_ok;
    logic                    w_align_ok;
    logic                    w_req_err;
    logic                    w_accept;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load_data;
    logic [DATA_WIDTH-1:0]   w_merge;

    assign w_accept = (r_state == c_IDLE) && req_valid;

    // Legality of the incoming request, evaluated on the raw req_* inputs
    always_comb begin
        w_f3_ok = 1'b0;
        case (req_funct3)
            c_F3_B, c_F3_H, c_F3_W: w_f3_ok = 1'b1;
            c_F3_BU, c_F3_HU:       w_f3_ok = ~req_write;
            default:                w_f3_ok = 1'b0;
        endcase
        w_align_ok = 1'b1;
        case (req_funct3[1:0])
            2'b01:   w_align_ok = ~req_addr[0];
            2'b10:   w_align_ok = (req_addr[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
        w_req_err = ~(w_f3_ok & w_align_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    if (w_req_err)
                        w_next_state = c_RESP;
                    else if (!req_write)
                        w_next_state = c_LOAD;
                    else if (req_funct3[1:0] == 2'b10)
                        w_next_state = c_STORE;
                    else
                        w_next_state = c_RMW_RD;
                end
            end
            c_LOAD:   w_next_state = c_RESP;
            c_STORE:  w_next_state = c_RESP;
            c_RMW_RD: w_next_state = c_RMW_WR;
            c_RMW_WR: w_next_state = c_RESP;
            c_RESP:   w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == c_IDLE);
        resp_valid = (r_state == c_RESP);
        mem_read   = (r_state == c_LOAD)  || (r_state == c_RMW_RD);
        mem_write  = (r_state == c_STORE) || (r_state == c_RMW_WR);
    end

    assign mem_addr   = r_addr[ADDR_WIDTH+1:2];
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Load lane select and extension
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            c_F3_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load_data = {{16{w_half[15]}}, w_half};
            c_F3_W:  w_load_data = mem_rdata;
            c_F3_BU: w_load_data = {24'd0, w_byte};
            c_F3_HU: w_load_data = {16'd0, w_half};
            default: w_load_data = '0;
        endcase
    end

    // Store lane insertion over the word read back in RMW_RD
    always_comb begin
        w_merge = mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wdata[7:0];
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata;
        end else begin
            w_merge[15:0] = r_wdata;
        end
    end

    // The merge is registered at the RMW_RD edge so mem_wdata is glitch-free
    // in RMW_WR and simply holds its last value in IDLE and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata[15:0];
                        if (w_req_err) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else if (req_write && (req_funct3[1:0] == 2'b10)) begin
                            r_mem_wdata <= req_wdata;
                        end
                    end
                end
                c_LOAD: begin
                    r_rdata <= w_load_data;
                    r_err   <= 1'b0;
                end
                c_STORE, c_RMW_WR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                c_RMW_RD: begin
                    r_mem_wdata <= w_merge;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed scoreboard bench for load_store_unit with a word memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response pops one expectation
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata 0x%08h err %0d expected no response", resp_rdata, resp_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_err", {31'b0, resp_err}, {31'b0, mon_e[32]});
                check("resp_rdata", resp_rdata, mon_e[31:0]);
            end
        end
    end

    task automatic do_req(input string name, input logic w, input logic [2:0] f3,
                          input logic [11:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_nrd, input int exp_nwr);
        int guard, lat, nrd, nwr;
        logic act;
        logic [9:0] seen_addr;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s ready_timeout: got req_ready 0 expected 1", name);
            return;
        end
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        exp_q.push_back({exp_err, exp_rd});
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; act = 1'b0; seen_addr = '0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            if (mem_read || mem_write) begin
                act = 1'b1;
                seen_addr = mem_addr;
            end
        end while (!resp_valid && lat < 20);
        check({name, " latency"}, lat, exp_lat);
        check({name, " mem_read_cycles"}, nrd, exp_nrd);
        check({name, " mem_write_cycles"}, nwr, exp_nwr);
        if (act) check({name, " mem_addr"}, {22'b0, seen_addr}, {22'b0, addr[11:2]});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        #1;
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset mem_write", {31'b0, mem_write}, 32'd0);
        check("reset mem_read", {31'b0, mem_read}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset req_ready", {31'b0, req_ready}, 32'd1);
        check("post_reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("post_reset mem_write", {31'b0, mem_write}, 32'd0);

        //      name       w     f3      addr     wdata          exp_rdata     err lat rd wr
        do_req("SW1",     1'b1, 3'b010, 12'h014, 32'h12345678, 32'h00000000, 1'b0, 2, 0, 1);
        check("mem5 after SW1", mem[5], 32'h12345678);
        do_req("LW",      1'b0, 3'b010, 12'h014, 32'h0,        32'h12345678, 1'b0, 2, 1, 0);
        do_req("LB017",   1'b0, 3'b000, 12'h017, 32'h0,        32'h00000012, 1'b0, 2, 1, 0);
        do_req("LB014",   1'b0, 3'b000, 12'h014, 32'h0,        32'h00000078, 1'b0, 2, 1, 0);
        do_req("LH016",   1'b0, 3'b001, 12'h016, 32'h0,        32'h00001234, 1'b0, 2, 1, 0);
        do_req("LBU015",  1'b0, 3'b100, 12'h015, 32'h0,        32'h00000056, 1'b0, 2, 1, 0);
        do_req("SW2",     1'b1, 3'b010, 12'h014, 32'h80FF0000, 32'h00000000, 1'b0, 2, 0, 1);
        do_req("LHneg",   1'b0, 3'b001, 12'h016, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0);
        do_req("LHU",     1'b0, 3'b101, 12'h016, 32'h0,        32'h000080FF, 1'b0, 2, 1, 0);
        do_req("LBneg",   1'b0, 3'b000, 12'h016, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0);
        do_req("SW3",     1'b1, 3'b010, 12'h014, 32'h12345678, 32'h00000000, 1'b0, 2, 0, 1);
        do_req("SB015",   1'b1, 3'b000, 12'h015, 32'hFFFFFFAB, 32'h00000000, 1'b0, 3, 1, 1);
        check("mem5 after SB", mem[5], 32'h1234AB78);
        do_req("SH016",   1'b1, 3'b001, 12'h016, 32'h1111BEEF, 32'h00000000, 1'b0, 3, 1, 1);
        check("mem5 after SH", mem[5], 32'hBEEFAB78);
        do_req("SW8",     1'b1, 3'b010, 12'h020, 32'h00000000, 32'h00000000, 1'b0, 2, 0, 1);
        do_req("SB023",   1'b1, 3'b000, 12'h023, 32'h000000CD, 32'h00000000, 1'b0, 3, 1, 1);
        check("mem8 after SB lane3", mem[8], 32'hCD000000);
        do_req("LHU022",  1'b0, 3'b101, 12'h022, 32'h0,        32'h0000CD00, 1'b0, 2, 1, 0);
        do_req("LW5",     1'b0, 3'b010, 12'h014, 32'h0,        32'hBEEFAB78, 1'b0, 2, 1, 0);
        do_req("ERR_LW",  1'b0, 3'b010, 12'h016, 32'h0,        32'h00000000, 1'b1, 1, 0, 0);
        do_req("ERR_SH",  1'b1, 3'b001, 12'h015, 32'h5555AAAA, 32'h00000000, 1'b1, 1, 0, 0);
        do_req("ERR_F3",  1'b0, 3'b011, 12'h014, 32'h0,        32'h00000000, 1'b1, 1, 0, 0);
        do_req("ERR_SBU", 1'b1, 3'b100, 12'h014, 32'h11111111, 32'h00000000, 1'b1, 1, 0, 0);
        do_req("ERR_LH",  1'b0, 3'b001, 12'h013, 32'h0,        32'h00000000, 1'b1, 1, 0, 0);
        check("mem5 after errors", mem[5], 32'hBEEFAB78);

        // Reset asserted while an SB sits in RMW_RD
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 12'h014; req_wdata = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_mid in RMW_RD", {31'b0, mem_read}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mid resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mid resp_rdata", resp_rdata, 32'd0);
        check("rst_mid mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mid mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_mid mem_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_mid mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid mem5 unchanged", mem[5], 32'hBEEFAB78);
        check("rst_mid ready after release", {31'b0, req_ready}, 32'd1);

        // req_valid held high with changing payload while busy
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 12'h014; req_wdata = '0;
        exp_q.push_back({1'b0, 32'hBEEFAB78});
        @(posedge clk);
        #1 req_funct3 = 3'b100; req_addr = 12'h017; req_wdata = 32'hDEADBEEF;
        exp_q.push_back({1'b0, 32'h000000BE});
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!resp_valid && guard < 20);
        check("busy first latency", guard, 32'd2);
        @(negedge clk);
        check("busy ready after resp", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!resp_valid && guard < 20);
        check("busy second latency", guard, 32'd2);

        repeat (5) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
